// File: rtl/fcmp_if.sv
// ----------------------------------------------------------------------------
// fcmp_if -- operation/result handshake bundle for fcmp_pipe.
//
// Signals:
//   in_valid  : operation offered                 (master -> slave)
//   in_ready  : operation accepted this cycle     (slave  -> master)
//   op        : 00 feq, 01 flt, 10 fle, 11 rsvd   (master -> slave)
//   x1, x2    : IEEE-754 single operands          (master -> slave)
//   in_tag    : sideband tag                      (master -> slave)
//   y         : all-ones true / all-zeros false   (slave  -> master)
//   out_valid : y/out_tag hold a result           (slave  -> master)
//   out_ready : consumer takes the result         (master -> slave)
//   out_tag   : tag belonging to y                (slave  -> master)
// ----------------------------------------------------------------------------
interface fcmp_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      y;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op, x1, x2, in_tag, out_ready,
        input  in_ready, y, out_valid, out_tag
    );

    modport slave (
        input  in_valid, op, x1, x2, in_tag, out_ready,
        output in_ready, y, out_valid, out_tag
    );
endinterface

// File: rtl/fcmp_pipe.sv
// ----------------------------------------------------------------------------
// fcmp_pipe -- pipelined single-precision compare (feq / flt / fle).
//
// The comparison is evaluated combinationally on the accepted operands and
// only the one-bit result plus the tag travel down LATENCY register stages.
// Each stage loads when it is empty or when its contents move on, so bubbles
// collapse even while the output is stalled.
//
// Ports:
//   sys_clk : clock, rising edge
//   rstn    : synchronous active-low reset (clears valid, result and tag)
//   bus     : fcmp_if.slave handshake bundle (see rtl/fcmp_if.sv)
//
// Parameters:
//   LATENCY : register stages from acceptance to output, 1..4
//   TAG_W   : sideband tag width
//
// Build option:
//   FCMP_IEEE_EN defined   -> NaN operands compare false for every op and
//                             +0 / -0 compare equal.
//   FCMP_IEEE_EN undefined -> feq is raw bit equality, ordering is pure
//                             sign-magnitude (-0 < +0, NaN ordered by bits).
// ----------------------------------------------------------------------------
module fcmp_pipe #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic  sys_clk,
    input  logic  rstn,
    fcmp_if.slave bus
);

    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] res_p;
    logic [TAG_W-1:0]   tag_p [LATENCY];
    logic [LATENCY-1:0] ld;
    logic               res_c;

    function automatic logic fcmp(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
        logic        eq;
        logic        lt;
        logic [30:0] ma;
        logic [30:0] mb;
        ma = a[30:0];
        mb = b[30:0];
        // Sign-magnitude ordering: differing signs -> the negative one is
        // smaller; two negatives order by reversed magnitude.
        if (a[31] != b[31]) begin
            lt = a[31];
        end else if (!a[31]) begin
            lt = (ma < mb);
        end else begin
            lt = (ma > mb);
        end
        eq = (a == b);
`ifdef FCMP_IEEE_EN
        begin
            logic nan_any;
            logic zeros;
            nan_any = ((a[30:23] == 8'hFF) && (a[22:0] != 23'd0)) ||
                      ((b[30:23] == 8'hFF) && (b[22:0] != 23'd0));
            zeros   = (ma == 31'd0) && (mb == 31'd0);
            if (nan_any) begin
                eq = 1'b0;
                lt = 1'b0;
            end else if (zeros) begin
                eq = 1'b1;
                lt = 1'b0;
            end
        end
`endif
        case (op)
            2'b00:   fcmp = eq;
            2'b01:   fcmp = lt;
            2'b10:   fcmp = lt | eq;
            default: fcmp = 1'b0;
        endcase
    endfunction

    assign res_c = fcmp(bus.op, bus.x1, bus.x2);

    // Stage k may load unless it and every stage after it are full while the
    // output is stalled. Written as a scan over valid bits so the load
    // vector never depends on itself.
    always_comb begin
        ld = '0;
        for (int k = 0; k < LATENCY; k++) begin
            logic tail_full;
            tail_full = 1'b1;
            for (int j = k; j < LATENCY; j++) begin
                tail_full = tail_full & vld_p[j];
            end
            ld[k] = bus.out_ready | ~tail_full;
        end
    end

    // ---- stage 1 .. LATENCY registers ----
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            vld_p <= '0;
            res_p <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                vld_p[0] <= bus.in_valid;
                res_p[0] <= res_c;
                tag_p[0] <= bus.in_tag;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (ld[k]) begin
                    vld_p[k] <= vld_p[k-1];
                    res_p[k] <= res_p[k-1];
                    tag_p[k] <= tag_p[k-1];
                end
            end
        end
    end

    // ---- output stage ----
    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_p[LATENCY-1];
    assign bus.y         = {32{res_p[LATENCY-1]}};
    assign bus.out_tag   = tag_p[LATENCY-1];

endmodule

// File: tb/tb_fcmp_pipe.sv
// ----------------------------------------------------------------------------
// tb_fcmp_pipe -- self-checking bench for fcmp_pipe.
// A scoreboard queue holds the result each accepted operation must produce,
// computed from an integer ordering key; one negedge process compares every
// meaningful output cycle against it. Directed tests add literal checks.
// ----------------------------------------------------------------------------
module tb_fcmp_pipe;
    localparam int LATENCY = 2;
    localparam int TAG_W   = 4;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    fcmp_if #(.TAG_W(TAG_W)) bus ();

    fcmp_pipe #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic             res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        raw;
        logic        ieee;
    } vec_t;

    exp_t             q[$];
    logic [TAG_W-1:0] out_tags[$];
    int               n_chk  = 0;
    int               n_pass = 0;
    int               n_out  = 0;
    logic             rst_at_edge = 1'b0;
    logic             prev_stall  = 1'b0;
    logic [31:0]      prev_y;
    logic [TAG_W-1:0] prev_tag;
    logic             saw_in_ready_low = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Map a float bit pattern onto a totally ordered integer line.
    function automatic longint key(input logic [31:0] v, input bit ieee);
        longint m;
        m = longint'(v[30:0]);
        if (!v[31]) return m;
        return ieee ? -m : -m - 1;
    endfunction

    function automatic logic model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit ieee;
        bit nan_any;
        longint ka;
        longint kb;
`ifdef FCMP_IEEE_EN
        ieee = 1'b1;
`else
        ieee = 1'b0;
`endif
        nan_any = ((a[30:23] == 8'hFF) && (a[22:0] != 0)) ||
                  ((b[30:23] == 8'hFF) && (b[22:0] != 0));
        if (ieee && nan_any) return 1'b0;
        ka = key(a, ieee);
        kb = key(b, ieee);
        case (op)
            2'b00:   return ka == kb;
            2'b01:   return ka < kb;
            2'b10:   return ka <= kb;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge sys_clk) rst_at_edge <= !rstn;

    // Compare process: every negedge.
    always @(negedge sys_clk) begin
        if (rst_at_edge) begin
            chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_y", bus.y, 32'd0);
            chk("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                chk("sb_y", bus.y, {32{q[0].res}});
                chk("sb_tag", {28'd0, bus.out_tag}, {28'd0, q[0].tag});
            end
            if (prev_stall) begin
                chk("stall_y", bus.y, prev_y);
                chk("stall_tag", {28'd0, bus.out_tag}, {28'd0, prev_tag});
            end
        end else if (prev_stall) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        prev_stall = rstn && bus.out_valid && !bus.out_ready;
        prev_y     = bus.y;
        prev_tag   = bus.out_tag;
        if (bus.in_valid && !bus.in_ready) saw_in_ready_low = 1'b1;
        if (!rstn) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                out_tags.push_back(bus.out_tag);
                n_out++;
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{res: model(bus.op, bus.x1, bus.x2), tag: bus.in_tag});
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.x1       = a;
        bus.x2       = b;
        bus.in_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (bus.in_ready) begin
                @(posedge sys_clk);
                #1;
                return;
            end
        end
        chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [31:0] ey, input logic [TAG_W-1:0] et);
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (bus.out_valid) begin
                chk({nm, "_y"}, bus.y, ey);
                chk({nm, "_tag"}, {28'd0, bus.out_tag}, {28'd0, et});
                @(posedge sys_clk);
                #1;
                return;
            end
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called right after issue() returns: result must appear exactly LATENCY
    // cycles after acceptance.
    task automatic lat_check(input string nm, input logic [31:0] ey, input logic [TAG_W-1:0] et);
        for (int i = 1; i < LATENCY; i++) begin
            @(negedge sys_clk);
            chk({nm, "_early"}, {31'd0, bus.out_valid}, 32'd0);
        end
        @(negedge sys_clk);
        chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_y"}, bus.y, ey);
        chk({nm, "_tag"}, {28'd0, bus.out_tag}, {28'd0, et});
        @(posedge sys_clk);
        #1;
    endtask

    vec_t tv[12] = '{
        '{2'b01, 32'hBF800000, 32'h3F800000, 1'b1, 1'b1},
        '{2'b01, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0},
        '{2'b10, 32'h40000000, 32'h40000000, 1'b1, 1'b1},
        '{2'b00, 32'h7FC00000, 32'h7FC00000, 1'b1, 1'b0},
        '{2'b00, 32'h80000000, 32'h00000000, 1'b0, 1'b1},
        '{2'b01, 32'h80000000, 32'h00000000, 1'b1, 1'b0},
        '{2'b01, 32'hC0000000, 32'hBF800000, 1'b1, 1'b1},
        '{2'b10, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0},
        '{2'b01, 32'h3F800000, 32'h40000000, 1'b1, 1'b1},
        '{2'b10, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0},
        '{2'b01, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0},
        '{2'b00, 32'h3F800000, 32'h3F800001, 1'b0, 1'b0}
    };

    initial begin
        int base;
        logic e;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.x1        = 32'd0;
        bus.x2        = 32'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 rstn = 1'b1;
        @(negedge sys_clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge sys_clk);
        #1;

        // Basic latency: feq 1.0 == 1.0, tag 5.
        issue(2'b00, 32'h3F800000, 32'h3F800000, 4'd5);
        idle();
        lat_check("feq_lat", 32'hFFFFFFFF, 4'd5);

        // Reserved op: false, tag passes.
        issue(2'b11, 32'h3F800000, 32'h3F800000, 4'd3);
        idle();
        lat_check("rsvd_op", 32'h0, 4'd3);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
`ifdef FCMP_IEEE_EN
            e = tv[i].ieee;
`else
            e = tv[i].raw;
`endif
            chk($sformatf("model_vec%0d", i), {31'd0, model(tv[i].op, tv[i].a, tv[i].b)}, {31'd0, e});
            issue(tv[i].op, tv[i].a, tv[i].b, TAG_W'(i));
            idle();
            wait_out($sformatf("vec%0d", i), {32{e}}, TAG_W'(i));
        end

        // Back-to-back stream with a mid-stream output stall.
        out_tags.delete();
        saw_in_ready_low = 1'b0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(2'(i % 3), 32'h3F800000 + 32'(i), 32'h3F800002, TAG_W'(i));
                idle();
            end
            begin
                repeat (3) @(posedge sys_clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge sys_clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge sys_clk);
        #1;
        chk("stream_count", 32'(n_out - base), 32'd6);
        chk("stream_in_ready_drop", {31'd0, saw_in_ready_low}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < out_tags.size()) chk($sformatf("stream_tag%0d", i), {28'd0, out_tags[i]}, 32'(i));
            else chk($sformatf("stream_tag%0d_missing", i), 32'd0, 32'd1);
        end

        // Reset with two operations in flight.
        issue(2'b00, 32'h40000000, 32'h40000000, 4'd1);
        issue(2'b00, 32'h40000000, 32'h40000000, 4'd2);
        idle();
        rstn = 1'b0;
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_y", bus.y, 32'd0);
        @(posedge sys_clk);
        #1 rstn = 1'b1;
        base = n_out;
        @(negedge sys_clk);
        chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (8) @(posedge sys_clk);
        #1;
        chk("no_stale", 32'(n_out - base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
